cordic_share_arb: RTL and testbench



---
 rtl/cordic_share_arb.sv | 114 +++++++++++
 tb/tb_cordic_share_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_share_arb.sv
// rtl/cordic_share_arb.sv - round-robin sharing of one fixed-latency CORDIC among NREQ requesters
// Requester tags ride a LAT-deep valid/tag shift pipeline alongside the CORDIC datapath.
module cordic_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = DW,
  parameter int LAT  = DW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pause,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DW-1:0]        req_x,
  input  logic [NREQ*DW-1:0]        req_y,
  input  logic [NREQ*AW-1:0]        req_a,
  output logic [NREQ-1:0]           res_valid,
  output logic [DW-1:0]             res_x,
  output logic [DW-1:0]             res_y,
  output logic [AW-1:0]             res_a,
  output logic                      c_rst,
  output logic                      c_en,
  output logic [DW-1:0]             c_xin,
  output logic [DW-1:0]             c_yin,
  output logic [AW-1:0]             c_ain,
  input  logic [DW-1:0]             c_xout,
  input  logic [DW-1:0]             c_yout,
  input  logic [AW-1:0]             c_aout,
  output logic [$clog2(LAT+1)-1:0]  inflight,
  output logic                      busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT+1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_any;
  logic [LAT-1:0] stg_valid;
  logic [IW-1:0]  stg_tag [LAT];
  logic [CW-1:0]  inflight_q;
  logic           retire;

  // Search starts just after the last granted requester, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rst_n && !pause) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IW'((int'(rr_ptr) + k) % NREQ);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    c_xin     = '0;
    c_yin     = '0;
    c_ain     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && grant_idx == IW'(i)) begin
        req_ready[i] = 1'b1;
        c_xin        = req_x[i*DW +: DW];
        c_yin        = req_y[i*DW +: DW];
        c_ain        = req_a[i*AW +: AW];
      end
    end
  end

  assign retire = stg_valid[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= IW'(NREQ-1);
      stg_valid  <= '0;
      inflight_q <= '0;
      for (int k = 0; k < LAT; k++) stg_tag[k] <= '0;
    end else begin
      if (grant_any) rr_ptr <= grant_idx;
      stg_valid[0] <= grant_any;
      stg_tag[0]   <= grant_idx;
      for (int k = 1; k < LAT; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_tag[k]   <= stg_tag[k-1];
      end
      case ({grant_any, retire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // A result landing during reset belongs to a discarded op, so the strobe is masked.
  always_comb begin
    res_valid = '0;
    if (rst_n && retire) res_valid[stg_tag[LAT-1]] = 1'b1;
  end

  assign res_x    = c_xout;
  assign res_y    = c_yout;
  assign res_a    = c_aout;
  assign c_rst    = ~rst_n;
  assign c_en     = 1'b1;
  assign inflight = rst_n ? inflight_q : '0;
  assign busy     = (inflight != '0);

endmodule

// File: tb/tb_cordic_share_arb.sv
// tb/tb_cordic_share_arb.sv - self-checking bench for cordic_share_arb
// Event-based reference: each issue is logged by cycle; results and inflight derive from that log.
module tb_cordic_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = DW;
  localparam int LAT  = DW + 1;
  localparam int CW   = $clog2(LAT+1);
  localparam int MAXC = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n, pause;
  logic [NREQ-1:0]      req_valid, req_ready, res_valid;
  logic [NREQ*DW-1:0]   req_x, req_y;
  logic [NREQ*AW-1:0]   req_a;
  logic [DW-1:0]        res_x, res_y, c_xin, c_yin, c_xout, c_yout;
  logic [AW-1:0]        res_a, c_ain, c_aout;
  logic                 c_rst, c_en, busy;
  logic [CW-1:0]        inflight;

  cordic_share_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_a(req_a),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_a(res_a),
    .c_rst(c_rst), .c_en(c_en), .c_xin(c_xin), .c_yin(c_yin), .c_ain(c_ain),
    .c_xout(c_xout), .c_yout(c_yout), .c_aout(c_aout),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr = NREQ-1;
  int last_rst = -1;
  int iss [MAXC];
  logic [NREQ-1:0] obs_ready [MAXC];
  logic [NREQ-1:0] obs_rv [MAXC];
  int obs_inf [MAXC];
  logic obs_crst [MAXC];
  logic ov_en = 1'b0;

  typedef struct {
    logic            p;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] ready;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic [NREQ-1:0] v);
    int idx, cnt, c;
    logic [NREQ-1:0] er, erv;
    rst_n = r; pause = p; req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = DW'($urandom);
      req_y[i*DW +: DW] = DW'($urandom);
      req_a[i*AW +: AW] = AW'($urandom);
    end
    if (ov_en) begin
      req_x[2*DW +: DW] = DW'(30000);
      req_y[2*DW +: DW] = '0;
      req_a[2*AW +: AW] = AW'('h2000);
    end
    c_xout = DW'($urandom); c_yout = DW'($urandom); c_aout = AW'($urandom);
    #1;
    idx = -1;
    er  = '0;
    if (r && !p)
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (rr + k) % NREQ;
        if (idx < 0 && v[j]) idx = j;
      end
    if (idx >= 0) er[idx] = 1'b1;
    erv = '0;
    c = cyc - LAT;
    if (r && c >= 0 && iss[c] >= 0 && c > last_rst) erv[iss[c]] = 1'b1;
    cnt = 0;
    if (r)
      for (int q = cyc - LAT; q < cyc; q++)
        if (q >= 0 && iss[q] >= 0 && q > last_rst) cnt++;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("c_xin", 64'(c_xin), idx >= 0 ? 64'(req_x[idx*DW +: DW]) : 64'd0);
    chk("c_yin", 64'(c_yin), idx >= 0 ? 64'(req_y[idx*DW +: DW]) : 64'd0);
    chk("c_ain", 64'(c_ain), idx >= 0 ? 64'(req_a[idx*AW +: AW]) : 64'd0);
    chk("res_valid", 64'(res_valid), 64'(erv));
    if (erv != '0) begin
      chk("res_x", 64'(res_x), 64'(c_xout));
      chk("res_y", 64'(res_y), 64'(c_yout));
      chk("res_a", 64'(res_a), 64'(c_aout));
    end
    chk("inflight", 64'(inflight), 64'(cnt));
    chk("busy", 64'(busy), 64'(cnt != 0));
    chk("c_rst", 64'(c_rst), 64'(!r));
    chk("c_en", 64'(c_en), 64'd1);
    obs_ready[cyc] = req_ready;
    obs_rv[cyc]    = res_valid;
    obs_inf[cyc]   = int'(inflight);
    obs_crst[cyc]  = c_rst;
    iss[cyc] = idx;
    if (idx >= 0) rr = idx;
    if (!r) begin
      rr = NREQ-1;
      last_rst = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < MAXC; i++) iss[i] = -1;
    rst_n = 1'b0; pause = 1'b0; req_valid = '0;
    req_x = '0; req_y = '0; req_a = '0;
    c_xout = '0; c_yout = '0; c_aout = '0;
    @(negedge clk);

    // Grant table from reset (rr starts at 3).
    tbl[0] = '{1'b0, 4'b1111, 4'b0001};
    tbl[1] = '{1'b0, 4'b1111, 4'b0010};
    tbl[2] = '{1'b0, 4'b0101, 4'b0100};
    tbl[3] = '{1'b0, 4'b0101, 4'b0001};
    tbl[4] = '{1'b1, 4'b1111, 4'b0000};
    tbl[5] = '{1'b0, 4'b1000, 4'b1000};
    tbl[6] = '{1'b0, 4'b0000, 4'b0000};
    tbl[7] = '{1'b0, 4'b0011, 4'b0001};
    tbl[8] = '{1'b0, 4'b0011, 4'b0010};
    tbl[9] = '{1'b0, 4'b0011, 4'b0001};
    do_reset();
    chk("reset_inflight", 64'(obs_inf[cyc-1]), 64'd0);
    chk("reset_ready", 64'(obs_ready[cyc-1]), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].p, tbl[i].v);
      chk("tbl_ready", 64'(obs_ready[cyc-1]), 64'(tbl[i].ready));
    end
    idle(LAT + 2);

    // Single op from requester 2.
    do_reset();
    ov_en = 1'b1;
    c0 = cyc;
    step(1'b1, 1'b0, 4'b0100);
    ov_en = 1'b0;
    idle(LAT + 2);
    chk("t1_ready", 64'(obs_ready[c0]), 64'b0100);
    chk("t1_rv_early", 64'(obs_rv[c0+LAT-1]), 64'd0);
    chk("t1_rv", 64'(obs_rv[c0+LAT]), 64'b0100);
    chk("t1_inf1", 64'(obs_inf[c0+1]), 64'd1);
    chk("t1_inf0", 64'(obs_inf[c0+LAT+1]), 64'd0);

    // All four valid for 12 cycles.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 4'b1111);
    idle(LAT + 1);
    for (int k = 0; k < 12; k++) begin
      chk("t2_grant", 64'(obs_ready[c0+k]), 64'(1 << (k % 4)));
      chk("t2_rv", 64'(obs_rv[c0+LAT+k]), 64'(1 << (k % 4)));
    end

    // Lone requester 1 for 20 cycles.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 4'b0010);
    idle(LAT + 1);
    chk("t3_sat", 64'(obs_inf[c0+LAT]), 64'(LAT));
    for (int k = 0; k < 20; k++) begin
      chk("t3_ready", 64'(obs_ready[c0+k]), 64'b0010);
      chk("t3_rv", 64'(obs_rv[c0+LAT+k]), 64'b0010);
    end

    // Pause for relative cycles 5..9.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 15; k++) step(1'b1, (k >= 5 && k <= 9), 4'b1111);
    idle(LAT + 1);
    for (int k = 5; k <= 9; k++) begin
      chk("t4_noready", 64'(obs_ready[c0+k]), 64'd0);
      chk("t4_bubble", 64'(obs_rv[c0+LAT+k]), 64'd0);
    end
    chk("t4_resume", 64'(obs_ready[c0+10]), 64'b0010);

    // Reset with 10 ops in flight.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 4'b1111);
    chk("t5_inf", 64'(obs_inf[c0+10]), 64'd0);
    chk("t5_crst", 64'(obs_crst[c0+10]), 64'd1);
    idle(20);
    for (int k = 11; k <= 30; k++) chk("t5_norv", 64'(obs_rv[c0+k]), 64'd0);

    // Requester 3 drops valid before being granted.
    do_reset();
    c0 = cyc;
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    for (int k = 0; k < 8; k++) step(1'b1, k[0], 4'b0111);
    idle(LAT + 3);
    for (int k = c0; k < cyc; k++) begin
      chk("t6_ready3", 64'(obs_ready[k][3]), 64'd0);
      chk("t6_rv3", 64'(obs_rv[k][3]), 64'd0);
    end

    // Randomized traffic against the reference.
    do_reset();
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0), NREQ'($urandom));
    idle(LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
